// File: rtl/mem_load_unit.sv
// mem_load_unit
// Load-side data memory access unit for the MEM stage. Issues a word-aligned
// read over a req/gnt/rvalid handshake, stalls the pipeline until the data
// returns, then extracts the addressed byte/halfword/word and sign- or
// zero-extends it into mem_DM_out for the MEM/WB register.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   ld_valid            MEM stage holds a load (stable while stall=1)
//   ld_addr/size/signed load byte address, size (00 B, 01 H, 10 W), sign-extend
//   stall               freeze IF..MEM pipeline registers
//   dm_req, dm_addr     registered read request and word address
//   dm_gnt, dm_rvalid   memory accepted request / read data valid
//   dm_rdata            read word, little-endian byte lanes
//   mem_DM_out          extended load result (held until the next load ends)
//   mem_ld_done         one-cycle pulse when a load finishes (ok or error)
//   mem_ld_err          error status of the last finished load
module mem_load_unit #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic        stall,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic [31:0] mem_DM_out,
    output logic        mem_ld_done,
    output logic        mem_ld_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_reg, state_next;
    logic [1:0]        off_reg, off_next;      // byte offset within the word
    logic [1:0]        size_reg, size_next;
    logic              sext_reg, sext_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic [31:0]       dm_addr_reg, dm_addr_next;
    logic [31:0]       out_reg, out_next;
    logic              err_reg, err_next;
    logic              done_reg, done_next;

    logic              misaligned;
    logic [7:0]        lane [4];
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       ext_val;

    // Split the returned word into its byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = dm_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_val = lane[off_reg];
    assign half_val = off_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        ext_val = dm_rdata;
        case (size_reg)
            2'b00:   ext_val = {{24{sext_reg & byte_val[7]}}, byte_val};
            2'b01:   ext_val = {{16{sext_reg & half_val[15]}}, half_val};
            default: ext_val = dm_rdata;
        endcase
    end

    // Reserved size counts as misaligned so it takes the same error path.
    always_comb begin
        misaligned = 1'b0;
        case (ld_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ld_addr[0];
            2'b10:   misaligned = |ld_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            off_reg     <= '0;
            size_reg    <= '0;
            sext_reg    <= 1'b0;
            cnt_reg     <= '0;
            req_reg     <= 1'b0;
            dm_addr_reg <= '0;
            out_reg     <= '0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            off_reg     <= off_next;
            size_reg    <= size_next;
            sext_reg    <= sext_next;
            cnt_reg     <= cnt_next;
            req_reg     <= req_next;
            dm_addr_reg <= dm_addr_next;
            out_reg     <= out_next;
            err_reg     <= err_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        off_next     = off_reg;
        size_next    = size_reg;
        sext_next    = sext_reg;
        cnt_next     = cnt_reg;
        req_next     = req_reg;
        dm_addr_next = dm_addr_reg;
        out_next     = out_reg;
        err_next     = err_reg;
        done_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ld_valid) begin
                    off_next  = ld_addr[1:0];
                    size_next = ld_size;
                    sext_next = ld_signed;
                    if (misaligned) begin
                        state_next = S_DONE;
                        out_next   = '0;
                        err_next   = 1'b1;
                        done_next  = 1'b1;
                    end else begin
                        state_next   = S_REQ;
                        req_next     = 1'b1;
                        dm_addr_next = {ld_addr[31:2], 2'b00};
                        cnt_next     = '0;
                    end
                end
            end
            S_REQ: begin
                // A grant in the final budget cycle is too late: timeout wins.
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_DONE;
                    req_next   = 1'b0;
                    out_next   = '0;
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (dm_gnt) begin
                        req_next   = 1'b0;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // rvalid is checked first so it beats a coincident timeout.
                if (dm_rvalid) begin
                    state_next = S_DONE;
                    out_next   = ext_val;
                    err_next   = 1'b0;
                    done_next  = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_DONE;
                    out_next   = '0;
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign stall       = ((state_reg == S_IDLE) && ld_valid) ||
                         (state_reg == S_REQ) || (state_reg == S_WAIT);
    assign dm_req      = req_reg;
    assign dm_addr     = dm_addr_reg;
    assign mem_DM_out  = out_reg;
    assign mem_ld_done = done_reg;
    assign mem_ld_err  = err_reg;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit
// Drives loads with random addresses, sizes and handshake delays. For every
// load the expected cycle-by-cycle outputs are derived from the load timeline
// (request phase until grant, wait phase until rvalid, timeout budget) and a
// shift/mask extraction model; a single compare process checks them every
// cycle. Directed loads additionally pin hand-computed literal results.
module tb_mem_load_unit;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        stall;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] mem_DM_out;
    logic        mem_ld_done;
    logic        mem_ld_err;

    mem_load_unit #(.TIMEOUT_CYC(T), .CNT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .stall      (stall),
        .dm_req     (dm_req),
        .dm_addr    (dm_addr),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_DM_out (mem_DM_out),
        .mem_ld_done(mem_ld_done),
        .mem_ld_err (mem_ld_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs for the current cycle.
    bit          check_en = 0;
    logic        exp_stall, exp_req, exp_done, exp_err;
    logic [31:0] exp_out, exp_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("dm_req", 32'(dm_req), 32'(exp_req));
            chk("mem_ld_done", 32'(mem_ld_done), 32'(exp_done));
            chk("mem_DM_out", mem_DM_out, exp_out);
            chk("mem_ld_err", 32'(mem_ld_err), 32'(exp_err));
            if (exp_req) chk("dm_addr", dm_addr, exp_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load result from the rules: shift the addressed lane down, mask to
    // the access width, then fill upwards with the lane MSB if signed.
    function automatic logic [31:0] ref_ext(input logic [31:0] a, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] rd);
        int nbits = 8 << sz;
        longint unsigned mask = (64'd1 << nbits) - 64'd1;
        longint unsigned v = ({32'd0, rd} >> (8 * (a % 4))) & mask;
        if (sg && (((v >> (nbits - 1)) & 64'd1) != 0)) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    // One complete load. g = REQ-phase cycle index at which gnt is given,
    // rv = extra WAIT cycles before rvalid. Cycle k=0 is the first REQ cycle.
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                           input int g, input int rv, input logic [31:0] rd, input bit stray);
        bit          bad, tmo;
        int          rvk, done_k;
        logic [31:0] res;
        bad = ref_bad(a, sz);
        rvk = g + 1 + rv;
        tmo = !bad && (rvk > T - 1);
        done_k = bad ? 0 : (tmo ? T : rvk + 1);
        res = (bad || tmo) ? 32'd0 : ref_ext(a, sz, sg, rd);

        // IDLE cycle presenting the load
        ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_signed = sg;
        dm_gnt = 1'b0; dm_rvalid = stray ? 1'(($urandom_range(0, 1))) : 1'b0;
        dm_rdata = $urandom;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        tick;

        for (int k = 0; k < done_k; k++) begin
            dm_gnt = (k == g);
            if (k == rvk) begin
                dm_rvalid = 1'b1;
                dm_rdata  = rd;
            end else begin
                dm_rvalid = (stray && k <= g) ? 1'($urandom_range(0, 1)) : 1'b0;
                dm_rdata  = $urandom;
            end
            exp_stall = 1'b1;
            exp_req   = (k <= g);
            exp_addr  = {a[31:2], 2'b00};
            exp_done  = 1'b0;
            tick;
        end

        // DONE cycle: a held ld_valid here belongs to the finished load
        dm_gnt = 1'b0; dm_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        dm_rdata = $urandom;
        ld_valid = 1'($urandom_range(0, 1));
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1;
        exp_out = res; exp_err = bad | tmo;
        tick;

        // idle gap with stray rvalid noise; outputs must hold
        ld_valid = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i < 1 + int'($urandom_range(0, 2)); i++) begin
            dm_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            dm_rdata  = $urandom;
            tick;
        end
        dm_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          g, rv;

        rst = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_signed = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_out = '0; exp_addr = '0;
        tick;
        tick;
        check_en = 1;
        tick;
        chk("reset dm_addr", dm_addr, 32'h0);
        rst = 1'b1;
        tick;

        // directed loads with literal results
        do_load(32'h100, 2'b10, 1'b0, 0, 0, 32'hDEADBEEF, 0);
        chk("word 0x100", mem_DM_out, 32'hDEADBEEF);
        chk("word 0x100 err", 32'(mem_ld_err), 32'd0);
        do_load(32'h103, 2'b00, 1'b1, 0, 0, 32'h80FF1234, 0);
        chk("sbyte 0x103", mem_DM_out, 32'hFFFFFF80);
        do_load(32'h103, 2'b00, 1'b0, 1, 1, 32'h80FF1234, 0);
        chk("ubyte 0x103", mem_DM_out, 32'h00000080);
        do_load(32'h102, 2'b01, 1'b1, 0, 2, 32'h80FF1234, 0);
        chk("shalf 0x102", mem_DM_out, 32'hFFFF80FF);
        do_load(32'h102, 2'b10, 1'b0, 0, 0, 32'h11223344, 0);
        chk("misaligned word data", mem_DM_out, 32'h0);
        chk("misaligned word err", 32'(mem_ld_err), 32'd1);
        do_load(32'h104, 2'b11, 1'b0, 0, 0, 32'h11223344, 0);
        chk("size11 err", 32'(mem_ld_err), 32'd1);
        do_load(32'h208, 2'b10, 1'b0, 5, 2, 32'hCAFEF00D, 1);
        chk("delayed word", mem_DM_out, 32'hCAFEF00D);
        chk("delayed word err", 32'(mem_ld_err), 32'd0);
        do_load(32'h300, 2'b10, 1'b0, 0, 1000, 32'h0BADBAD0, 0);
        chk("timeout err", 32'(mem_ld_err), 32'd1);
        do_load(32'h301, 2'b00, 1'b1, 2, 0, 32'h00007F00, 0);
        chk("after timeout", mem_DM_out, 32'h0000007F);
        // rvalid in the last budget cycle succeeds; one later times out
        do_load(32'h400, 2'b10, 1'b0, 3, T - 5, 32'h55AA55AA, 1);
        chk("rvalid at last cycle", mem_DM_out, 32'h55AA55AA);
        do_load(32'h400, 2'b10, 1'b0, 3, T - 4, 32'h55AA55AA, 1);
        chk("rvalid one too late", 32'(mem_ld_err), 32'd1);
        do_load(32'h500, 2'b10, 1'b0, 1000, 0, 32'h1, 1);
        chk("never granted", 32'(mem_ld_err), 32'd1);
        do_load(32'h602, 2'b01, 1'b1, 0, 0, 32'h80FF1234, 0);
        chk("shalf refill", mem_DM_out, 32'hFFFF80FF);

        // reset while in WAIT
        ld_valid = 1'b1; ld_addr = 32'h200; ld_size = 2'b10; ld_signed = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        tick;
        dm_gnt = 1'b1; exp_req = 1'b1; exp_addr = 32'h200;
        tick;
        dm_gnt = 1'b0; exp_req = 1'b0; rst = 1'b0; ld_valid = 1'b0;
        tick;
        rst = 1'b1;
        exp_stall = 1'b0; exp_out = '0; exp_err = 1'b0; exp_done = 1'b0;
        chk("reset mid-load dm_addr", dm_addr, 32'h0);
        dm_rvalid = 1'b1; dm_rdata = 32'h12345678;
        tick;
        dm_rvalid = 1'b0;
        tick;
        tick;
        chk("stray rvalid after reset", mem_DM_out, 32'h0);

        // randomized loads
        for (int n = 0; n < 200; n++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b11) sz = 2'($urandom_range(0, 2));
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            g  = $urandom_range(0, 5);
            rv = ($urandom_range(0, 29) == 0) ? int'($urandom_range(T - 8, T)) : int'($urandom_range(0, 5));
            do_load(a, sz, 1'($urandom_range(0, 1)), g, rv, $urandom, 1'($urandom_range(0, 1)));
        end

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
